// File: rtl/conga_pkg.sv
// conga_pkg
//   Shared definitions for the conga chart reader: chart entry layout,
//   the chart terminator value, the default last song position and the
//   reader state encoding.
package conga_pkg;

    // Chart entry layout: [17:16] lane, [15:0] time.
    localparam int ENTRY_W = 18;
    localparam int LANE_HI = 17;
    localparam int LANE_LO = 16;
    localparam int TIME_HI = 15;
    localparam int TIME_LO = 0;

    // A time field of all ones marks the end of the chart.
    localparam logic [15:0] END_TIME = 16'hFFFF;

    // Last song position the counter ever reaches.
    localparam logic [15:0] MAXCOUNT_DEFAULT = 16'd39648;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ARMED = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Fired-note counter increments but sticks at its maximum.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/conga_chart_reader.sv
// conga_chart_reader
//   Walks a note chart held in an external synchronous ROM and fires a
//   one-cycle note event when the song position reaches each entry's time.
//
//   Optional feature macro: CHART_PREVIEW_EN (adds preview_valid/preview_lane).
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   asynchronous, active-high reset
//   go           in   restart the chart from entry 0
//   count        in   16-bit current song position
//   rom_addr     out  AW-bit chart ROM read address
//   rom_data     in   18-bit chart entry, valid one cycle after rom_addr
//   note_fire    out  one-cycle pulse when an entry is reached
//   note_lane    out  lane of the last fired note, held until next fire
//   chart_done   out  high once the terminator or end of ROM is reached
//   notes_fired  out  notes fired since go/reset, saturating at 1023
//   preview_valid out (CHART_PREVIEW_EN) upcoming note is within LEAD counts
//   preview_lane  out (CHART_PREVIEW_EN) lane of the upcoming note
module conga_chart_reader
    import conga_pkg::*;
#(
    parameter int          AW       = 8,
    parameter logic [15:0] MAXCOUNT = MAXCOUNT_DEFAULT
`ifdef CHART_PREVIEW_EN
    ,
    parameter logic [15:0] LEAD     = 16'd512
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [15:0]        count,
    output logic [AW-1:0]      rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic               note_fire,
    output logic [1:0]         note_lane,
    output logic               chart_done,
    output logic [9:0]         notes_fired
`ifdef CHART_PREVIEW_EN
    ,
    output logic               preview_valid,
    output logic [1:0]         preview_lane
`endif
);

    state_t      state;
    logic [1:0]  entry_lane;
    logic [15:0] entry_time;
    logic        fire_cond;

    // An entry fires once the song has reached its time. Entries beyond the
    // last song position are never reachable, so they are explicitly excluded
    // in case the counter ever reports something past its normal end.
    assign fire_cond = (state == ARMED) && (count >= entry_time) &&
                       (entry_time <= MAXCOUNT);

    // Reader FSM. The ROM is synchronous, so each entry costs one cycle to
    // present the address (FETCH) and one to capture the data (LOAD) before
    // it can be compared (ARMED). go overrides everything, including a fire
    // that would otherwise happen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rom_addr    <= '0;
            entry_lane  <= 2'd0;
            entry_time  <= 16'd0;
            note_fire   <= 1'b0;
            note_lane   <= 2'd0;
            chart_done  <= 1'b0;
            notes_fired <= 10'd0;
        end else if (go) begin
            state       <= FETCH;
            rom_addr    <= '0;
            note_fire   <= 1'b0;
            chart_done  <= 1'b0;
            notes_fired <= 10'd0;
        end else begin
            note_fire <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    entry_lane <= rom_data[LANE_HI:LANE_LO];
                    entry_time <= rom_data[TIME_HI:TIME_LO];
                    if (rom_data[TIME_HI:TIME_LO] == END_TIME) begin
                        state      <= DONE;
                        chart_done <= 1'b1;
                    end else begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (fire_cond) begin
                        note_fire   <= 1'b1;
                        note_lane   <= entry_lane;
                        notes_fired <= sat_inc10(notes_fired);
                        // The last ROM slot ends the chart rather than
                        // wrapping back to entry 0.
                        if (rom_addr == {AW{1'b1}}) begin
                            state      <= DONE;
                            chart_done <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    chart_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CHART_PREVIEW_EN
    logic [16:0] lead_sum;

    // The lead window is summed at 17 bits so a late-song position plus the
    // lead cannot wrap around and falsely look early.
    assign lead_sum      = {1'b0, count} + {1'b0, LEAD};
    assign preview_valid = (state == ARMED) && !fire_cond &&
                           (lead_sum >= {1'b0, entry_time});
    assign preview_lane  = (state == ARMED) ? entry_lane : 2'd0;
`endif

endmodule

// File: tb/tb_conga_chart_reader.sv
// tb_conga_chart_reader
//   Self-checking bench for conga_chart_reader. A behavioural synchronous ROM
//   feeds the reader; expected note events are queued when stimulus is set up
//   and popped as note_fire pulses appear.
module tb_conga_chart_reader;

    logic        clk;
    logic        reset;
    logic        go;
    logic [15:0] count;
    logic [7:0]  rom_addr;
    logic [17:0] rom_data;
    logic        note_fire;
    logic [1:0]  note_lane;
    logic        chart_done;
    logic [9:0]  notes_fired;
`ifdef CHART_PREVIEW_EN
    logic        preview_valid;
    logic [1:0]  preview_lane;
`endif

    typedef struct {
        logic [1:0] lane;
        logic [9:0] nfired;
    } fire_t;

    fire_t       fireQ[$];
    int          fireCycles[$];
    logic [17:0] rom [0:255];
    int          cycle;
    int          checks;
    int          failures;

    conga_chart_reader dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .count       (count),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_fire   (note_fire),
        .note_lane   (note_lane),
        .chart_done  (chart_done),
        .notes_fired (notes_fired)
`ifdef CHART_PREVIEW_EN
        ,
        .preview_valid (preview_valid),
        .preview_lane  (preview_lane)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous chart ROM, one cycle of read latency.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        cycle    <= cycle + 1;
    end

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Scoreboard: every observed fire must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && note_fire) begin
            fireCycles.push_back(cycle);
            if (fireQ.size() == 0) begin
                checkOutput("unexpected_fire", note_fire, 0);
            end else begin
                fire_t e;
                e = fireQ.pop_front();
                checkOutput("fire_lane", note_lane, e.lane);
                checkOutput("fire_notes_fired", notes_fired, e.nfired);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectFire(input logic [1:0] lane, input logic [9:0] nf);
        fire_t e;
        e.lane   = lane;
        e.nfired = nf;
        fireQ.push_back(e);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = {2'd0, 16'hFFFF};
    endtask

    // Drives go for one cycle together with a song position.
    task automatic applyStimulus(input logic [15:0] pos);
        count = pos;
        go    = 1'b1;
        tick(1);
        go    = 1'b0;
    endtask

    // Ramps the song position from lo to hi in the given step, one per cycle.
    task automatic rampCount(input int lo, input int hi, input int step);
        for (int c = lo; c <= hi; c += step) begin
            count = 16'(c);
            tick(1);
        end
        count = 16'(hi);
        tick(1);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput(tag, fireQ.size(), 0);
        fireQ.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        go       = 1'b0;
        count    = 16'd0;
        reset    = 1'b1;
        clearRom();
        tick(3);

        // Reset state.
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_note_fire", note_fire, 0);
        checkOutput("rst_note_lane", note_lane, 0);
        checkOutput("rst_chart_done", chart_done, 0);
        checkOutput("rst_notes_fired", notes_fired, 0);
        reset = 1'b0;
        tick(2);

        // Two-note chart with a steady ramp.
        clearRom();
        rom[0] = {2'd1, 16'd100};
        rom[1] = {2'd2, 16'd200};
        applyStimulus(16'd0);
        expectFire(2'd1, 10'd1);
        expectFire(2'd2, 10'd2);
        rampCount(0, 300, 1);
        tick(5);
        checkDrained("ramp_all_fired");
        checkOutput("ramp_chart_done", chart_done, 1);
        checkOutput("ramp_notes_fired", notes_fired, 2);

        // Three entries already passed: back-to-back fires every 3 cycles.
        clearRom();
        rom[0] = {2'd0, 16'd50};
        rom[1] = {2'd3, 16'd50};
        rom[2] = {2'd2, 16'd50};
        applyStimulus(16'd0);
        tick(5);
        fireCycles.delete();
        expectFire(2'd0, 10'd1);
        expectFire(2'd3, 10'd2);
        expectFire(2'd2, 10'd3);
        count = 16'd60;
        tick(20);
        checkDrained("burst_all_fired");
        checkOutput("burst_fire_count", fireCycles.size(), 3);
        if (fireCycles.size() == 3) begin
            checkOutput("burst_gap_1", fireCycles[1] - fireCycles[0], 3);
            checkOutput("burst_gap_2", fireCycles[2] - fireCycles[1], 3);
        end
        checkOutput("burst_chart_done", chart_done, 1);

        // Paused counter just short of an entry: nothing fires until it steps.
        clearRom();
        rom[0] = {2'd1, 16'd100};
        applyStimulus(16'd99);
        tick(1000);
        checkOutput("hold_notes_fired", notes_fired, 0);
        checkOutput("hold_rom_addr", rom_addr, 0);
        expectFire(2'd1, 10'd1);
        count = 16'd100;
        tick(10);
        checkDrained("hold_step_fired");
        checkOutput("hold_single_fire", notes_fired, 1);

        // Entry beyond the last song position never fires.
        clearRom();
        rom[0] = {2'd1, 16'd40000};
        applyStimulus(16'd0);
        rampCount(0, 39648, 8);
        tick(20);
        checkOutput("beyond_notes_fired", notes_fired, 0);
        checkOutput("beyond_chart_done", chart_done, 0);

        // Restart mid-chart, go beating a coincident fire, then async reset.
        clearRom();
        rom[0] = {2'd1, 16'd100};
        rom[1] = {2'd2, 16'd200};
        rom[2] = {2'd3, 16'd300};
        applyStimulus(16'd0);
        expectFire(2'd1, 10'd1);
        expectFire(2'd2, 10'd2);
        rampCount(0, 250, 1);
        tick(3);
        checkDrained("mid_two_fired");
        checkOutput("mid_notes_fired", notes_fired, 2);
        applyStimulus(16'd0);
        checkOutput("restart_notes_fired", notes_fired, 0);
        checkOutput("restart_rom_addr", rom_addr, 0);
        expectFire(2'd1, 10'd1);
        rampCount(0, 150, 1);
        tick(3);
        checkDrained("restart_refire");
        checkOutput("restart_one_fired", notes_fired, 1);
        // Entry @200 is armed; count jumps past it in the same cycle as go.
        expectFire(2'd1, 10'd1);
        expectFire(2'd2, 10'd2);
        applyStimulus(16'd250);
        checkOutput("gowins_note_fire", note_fire, 0);
        checkOutput("gowins_notes_fired", notes_fired, 0);
        tick(20);
        checkDrained("gowins_refires");
        checkOutput("gowins_notes_after", notes_fired, 2);
        // Entry @300 now armed; reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rom_addr", rom_addr, 0);
        checkOutput("async_note_lane", note_lane, 0);
        checkOutput("async_notes_fired", notes_fired, 0);
        checkOutput("async_chart_done", chart_done, 0);
        checkOutput("async_note_fire", note_fire, 0);
        tick(2);
        reset = 1'b0;
        tick(5);
        checkOutput("idle_after_reset", notes_fired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
